pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the MIPS core over a single-outstanding request/response handshake to instruction memory. It computes redirect targets for J-type jumps, PC-relative branches and register jumps (jr), and buffers one fetched instruction until decode accepts it. It sits between instruction memory and the decode stage and replaces free-running PC logic.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  fetch request valid (registered)
imem_addr  output  32  fetch address (registered)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  fetch response valid
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  buffered instruction available to decode
instr  output  32  buffered instruction
instr_pc  output  32  address of buffered instruction
instr_accept  input  1  decode consumes instr this cycle
redirect_jump  input  1  J-type redirect pulse
jump_index  input  26  instr_index field
redirect_branch  input  1  taken-branch redirect pulse
branch_offset  input  16  signed word offset
redirect_reg  input  1  jr redirect pulse
reg_target  input  32  jr target register value
redirect_base_pc  input  32  PC of the redirecting instruction
pc  output  32  next fetch address
addr_error  output  1  one-cycle pulse: misaligned jr target

Behaviour:
- Reset (synchronous, active-high, overrides everything): state=REQ, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, addr_error=0, kill=0. Reset mid-fetch abandons any outstanding response; a response arriving after reset is discarded (kill set on reset if state was WAIT).
- States: REQ, WAIT, HOLD.
- REQ: imem_req=1, imem_addr=pc. imem_ready=1 -> fetch_pc<=pc, imem_req<=0, go WAIT.
- WAIT: imem_req=0. imem_rvalid=1 and kill=0 -> instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1, pc<=fetch_pc+4, go HOLD. imem_rvalid=1 and kill=1 -> drop the data, kill<=0, go REQ.
- HOLD: instr_valid=1, contents stable. instr_accept=1 -> instr_valid<=0, go REQ (imem_req high the next cycle). Minimum 3 cycles per instruction at zero memory latency.
- Redirect targets, p4 = redirect_base_pc+4:
  jump = {p4[31:28], jump_index, 2'b00};
  branch = p4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}, modulo 2^32 (wraps, no error);
  reg = {reg_target[31:2], 2'b00}; addr_error pulses one cycle if reg_target[1:0]!=0.
- Priority if several redirects are asserted together: redirect_reg > redirect_jump > redirect_branch.
- Redirect (any state) -> pc<=target, and the following state-dependent action:
  REQ without imem_ready: imem_addr<=target next cycle, stay REQ.
  REQ with imem_ready: old fetch accepted, kill<=1, go WAIT.
  WAIT without rvalid: kill<=1.
  WAIT with rvalid: data dropped, go REQ.
  HOLD: instr_valid<=0, go REQ. With instr_accept in the same cycle, decode takes the instruction and the redirect still applies.
- pc after a redirect is never overwritten by fetch_pc+4 from a killed fetch.
- imem_addr changes only in REQ at reset, redirect or state entry. It is never changed while imem_req=1 and imem_ready=0, except on redirect.

Test Plan:
- Reset for 2 cycles, RESET_PC=0x0040_0000 -> imem_req=0 during reset; imem_req=1, imem_addr=0x0040_0000 on the first cycle after reset; instr_valid=0.
- Sequential fetch: zero-latency memory returning 0x2108_0001, instr_accept always 1 -> instr_pc = 0x0040_0000, 0x0040_0004, 0x0040_0008, one instruction every 3 cycles.
- Jump: redirect_base_pc=0x0040_0010, jump_index=0x010_0003 while in HOLD -> instr_valid drops; next imem_addr=0x0040_000C.
- Branch wrap: base=0xFFFF_FFF8, offset=0x0002 -> target 0x0000_0004. Base=0x100, offset=0xFFFF -> target 0x100.
- Redirect in WAIT with a 4-cycle memory latency: jr reg_target=0x0000_1002 -> addr_error pulses 1 cycle; the late response is dropped with instr_valid staying 0; next imem_addr=0x0000_1000.
- Simultaneous redirect_reg and redirect_branch, plus imem_ready stalled 5 cycles in REQ -> reg target wins; imem_req stays high; imem_addr is stable apart from the redirect update.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: one outstanding imem
// request, one buffered instruction for decode, jump/branch/jr redirects.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_accept,
  input  logic        redirect_jump,
  input  logic [25:0] jump_index,
  input  logic        redirect_branch,
  input  logic [15:0] branch_offset,
  input  logic        redirect_reg,
  input  logic [31:0] reg_target,
  input  logic [31:0] redirect_base_pc,
  output logic [31:0] pc,
  output logic        addr_error
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, imem_addr_nxt, fetch_pc, fetch_pc_nxt;
  logic [31:0] instr_nxt, instr_pc_nxt;
  logic        imem_req_nxt, instr_valid_nxt, addr_error_nxt;
  logic        kill, kill_nxt;

  logic        redirect, accept;
  logic [31:0] p4, jump_target, branch_target, reg_target_al, target;

  always_comb begin
    p4            = redirect_base_pc + 32'd4;
    jump_target   = {p4[31:28], jump_index, 2'b00};
    branch_target = p4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    reg_target_al = {reg_target[31:2], 2'b00};
    redirect      = redirect_reg | redirect_jump | redirect_branch;
    if (redirect_reg)       target = reg_target_al;
    else if (redirect_jump) target = jump_target;
    else                    target = branch_target;
  end

  assign accept = imem_req & imem_ready;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    imem_req_nxt    = imem_req;
    imem_addr_nxt   = imem_addr;
    fetch_pc_nxt    = fetch_pc;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    kill_nxt        = kill;
    addr_error_nxt  = redirect_reg & (reg_target[1:0] != 2'b00);
    if (redirect) pc_nxt = target;

    case (state)
      S_REQ: begin
        if (accept) begin
          fetch_pc_nxt = imem_addr;
          imem_req_nxt = 1'b0;
          state_nxt    = S_WAIT;
          if (redirect) kill_nxt = 1'b1;
        end else begin
          imem_req_nxt = 1'b1;
          if (redirect) imem_addr_nxt = target;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // Killed or redirected response: pc already holds the new target.
          if (kill || redirect) begin
            kill_nxt      = 1'b0;
            state_nxt     = S_REQ;
            imem_req_nxt  = 1'b1;
            imem_addr_nxt = redirect ? target : pc;
          end else begin
            instr_nxt       = imem_rdata;
            instr_pc_nxt    = fetch_pc;
            instr_valid_nxt = 1'b1;
            pc_nxt          = fetch_pc + 32'd4;
            state_nxt       = S_HOLD;
          end
        end else if (redirect) begin
          kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || instr_accept) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = S_REQ;
          imem_req_nxt    = 1'b1;
          imem_addr_nxt   = redirect ? target : pc;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      fetch_pc    <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      addr_error  <= 1'b0;
      // A response still in flight when reset hits must be discarded later.
      kill        <= (state == S_WAIT) && !imem_rvalid;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      imem_req    <= imem_req_nxt;
      imem_addr   <= imem_addr_nxt;
      fetch_pc    <= fetch_pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
      addr_error  <= addr_error_nxt;
      kill        <= kill_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a latency-programmable imem model
// and an expected-instruction scoreboard.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_accept = 1'b0;
  logic        redirect_jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        redirect_branch = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        redirect_reg = 1'b0;
  logic [31:0] reg_target = '0;
  logic [31:0] redirect_base_pc = '0;
  logic [31:0] pc;
  logic        addr_error;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;
  exp_t exp_q[$];

  int unsigned mem_lat = 0;
  bit          fixed_data = 1'b1;
  bit          pend = 1'b0;
  int unsigned cnt = 0;
  logic [31:0] paddr = '0;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_accept(instr_accept),
    .redirect_jump(redirect_jump), .jump_index(jump_index),
    .redirect_branch(redirect_branch), .branch_offset(branch_offset),
    .redirect_reg(redirect_reg), .reg_target(reg_target),
    .redirect_base_pc(redirect_base_pc),
    .pc(pc), .addr_error(addr_error)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return fixed_data ? 32'h2108_0001 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back('{mem_word(a), a});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) break;
    end
    check1(tag, instr_valid, 1'b1);
  endtask

  // Memory model: accepts on req&ready, answers after mem_lat extra cycles.
  always @(posedge clk) begin
    if (imem_rvalid) pend = 1'b0;
    if (imem_req === 1'b1 && imem_ready === 1'b1) begin
      pend  = 1'b1;
      cnt   = mem_lat;
      paddr = imem_addr;
    end
    #1;
    imem_rvalid = pend && (cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(paddr) : '0;
    if (pend && cnt != 0) cnt--;
  end

  // Scoreboard: each new buffered instruction must match the next expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected: got instr_pc %h expected no instruction", instr_pc);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", instr, e.word);
        check("sb_instr_pc", instr_pc, e.addr);
      end
    end
    prev_valid = instr_valid;
  end

  initial begin
    // Reset for two cycles
    tick();
    check1("reset_req", imem_req, 1'b0);
    tick();
    check1("reset_req2", imem_req, 1'b0);
    check("reset_addr", imem_addr, RPC);
    check("reset_pc", pc, RPC);
    check1("reset_valid", instr_valid, 1'b0);
    check1("reset_err", addr_error, 1'b0);
    reset = 1'b0;
    tick();
    check1("post_reset_req", imem_req, 1'b1);
    check("post_reset_addr", imem_addr, RPC);
    check1("post_reset_valid", instr_valid, 1'b0);

    // Sequential fetch, zero-latency memory, decode always accepts
    mem_lat = 0;
    fixed_data = 1'b1;
    push_exp(RPC);
    push_exp(RPC + 32'd4);
    push_exp(RPC + 32'd8);
    imem_ready = 1'b1;
    instr_accept = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check1("seq_cadence", instr_valid, (k % 3) == 2);
    end
    imem_ready = 1'b0;
    check1("seq_next_req", imem_req, 1'b1);
    check("seq_next_addr", imem_addr, RPC + 32'd12);

    // Fetch into HOLD, then jump redirect
    instr_accept = 1'b0;
    fixed_data = 1'b0;
    push_exp(RPC + 32'd12);
    imem_ready = 1'b1;
    wait_valid("hold_wait");
    imem_ready = 1'b0;
    tick();
    check1("hold_stable_valid", instr_valid, 1'b1);
    check("hold_stable_instr", instr, (RPC + 32'd12) ^ 32'h5A5A_0000);
    redirect_jump = 1'b1;
    redirect_base_pc = 32'h0040_0010;
    jump_index = 26'h010_0003;
    tick();
    redirect_jump = 1'b0;
    check1("jump_valid_drop", instr_valid, 1'b0);
    check1("jump_req", imem_req, 1'b1);
    check("jump_addr", imem_addr, 32'h0040_000C);
    check("jump_pc", pc, 32'h0040_000C);

    // Branch targets with wrap, redirect in stalled REQ
    redirect_branch = 1'b1;
    redirect_base_pc = 32'hFFFF_FFF8;
    branch_offset = 16'h0002;
    tick();
    check("branch_wrap_addr", imem_addr, 32'h0000_0004);
    check("branch_wrap_pc", pc, 32'h0000_0004);
    redirect_base_pc = 32'h0000_0100;
    branch_offset = 16'hFFFF;
    tick();
    redirect_branch = 1'b0;
    check("branch_neg_addr", imem_addr, 32'h0000_0100);
    check1("branch_req", imem_req, 1'b1);

    // jr redirect while WAIT with 4-cycle latency; late response dropped
    mem_lat = 4;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    redirect_reg = 1'b1;
    reg_target = 32'h0000_1002;
    tick();
    redirect_reg = 1'b0;
    check1("jr_err_pulse", addr_error, 1'b1);
    check("jr_pc", pc, 32'h0000_1000);
    check1("jr_wait_req", imem_req, 1'b0);
    tick();
    check1("jr_err_clear", addr_error, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check1("jr_drop_valid", instr_valid, 1'b0);
      if (imem_req === 1'b1) break;
    end
    check1("jr_refetch_req", imem_req, 1'b1);
    check("jr_refetch_addr", imem_addr, 32'h0000_1000);

    // reg beats branch; stall keeps req and address steady
    redirect_reg = 1'b1;
    reg_target = 32'h0000_2000;
    redirect_branch = 1'b1;
    redirect_base_pc = 32'h0000_0100;
    branch_offset = 16'h0010;
    tick();
    redirect_reg = 1'b0;
    redirect_branch = 1'b0;
    check("prio_reg_addr", imem_addr, 32'h0000_2000);
    check("prio_reg_pc", pc, 32'h0000_2000);
    check1("prio_reg_err", addr_error, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("stall_req", imem_req, 1'b1);
      check("stall_addr", imem_addr, 32'h0000_2000);
    end

    // jump beats branch
    redirect_jump = 1'b1;
    redirect_branch = 1'b1;
    redirect_base_pc = 32'h3000_0000;
    jump_index = 26'h000_0010;
    branch_offset = 16'h0010;
    tick();
    redirect_jump = 1'b0;
    redirect_branch = 1'b0;
    check("prio_jump_addr", imem_addr, 32'h3000_0040);

    // Fetch from the redirected address and continue sequentially
    mem_lat = 0;
    instr_accept = 1'b1;
    push_exp(32'h3000_0040);
    imem_ready = 1'b1;
    wait_valid("final_wait");
    imem_ready = 1'b0;
    tick();
    check1("final_valid", instr_valid, 1'b0);
    check1("final_req", imem_req, 1'b1);
    check("final_addr", imem_addr, 32'h3000_0044);
    tick();

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
